// File: rtl/huffman_table_seq_if.sv
// Purpose: bundles the upstream leaf-fetch handshake and the builder-side signals of the table sequencer.
// Latency: none (wiring only).
// Backpressure: upstream holds leaf_in_* until it raises lvl_valid while lvl_req is high.
interface huffman_table_seq_if;
    logic        lvl_req;
    logic [1:0]  lvl_idx;
    logic        lvl_valid;
    logic [12:0] leaf_in_A;
    logic [12:0] leaf_in_B;
    logic [12:0] leaf_in_C;
    logic [12:0] leaf_in_D;
    logic [12:0] leaf_A;
    logic [12:0] leaf_B;
    logic [12:0] leaf_C;
    logic [12:0] leaf_D;
    logic [1:0]  state;
    logic        bld_nRST;
    logic [15:0] code_in;

    // Sequencer side
    modport master (
        output lvl_req, lvl_idx, leaf_A, leaf_B, leaf_C, leaf_D, state, bld_nRST,
        input  lvl_valid, leaf_in_A, leaf_in_B, leaf_in_C, leaf_in_D, code_in
    );

    // Upstream tree logic and code-table builder side
    modport slave (
        input  lvl_req, lvl_idx, leaf_A, leaf_B, leaf_C, leaf_D, state, bld_nRST,
        output lvl_valid, leaf_in_A, leaf_in_B, leaf_in_C, leaf_in_D, code_in
    );
endinterface

// File: rtl/huffman_table_seq.sv
// Purpose: steps the Huffman code-table builder through NUM_LEVELS levels (fetch leaves, restart, run, capture).
// Latency: 1 + RST_CYCLES + RUN_CYCLES + 1 cycles per level once lvl_valid is high; done one cycle after last capture.
// Backpressure: waits in REQ indefinitely until upstream asserts lvl_valid; start is ignored while busy.
module huffman_table_seq #(
    parameter int NUM_LEVELS = 3,
    parameter int RST_CYCLES = 1,
    parameter int RUN_CYCLES = 10
) (
    input  logic                      CLK,
    input  logic                      nRST,
    input  logic                      start,
    input  logic                      abort,
    huffman_table_seq_if.master       bus,
    output logic [15:0]               CODE_TABLE,
    output logic                      lvl_done,
    output logic                      busy,
    output logic                      done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_RST  = 3'd2,
        S_RUN  = 3'd3,
        S_CAP  = 3'd4,
        S_DONE = 3'd5
    } fsm_t;

    localparam logic [7:0] RST_LAST = 8'(RST_CYCLES - 1);
    localparam logic [7:0] RUN_LAST = 8'(RUN_CYCLES - 1);
    localparam logic [1:0] LVL_LAST = 2'(NUM_LEVELS - 1);

    fsm_t        fsm_q;
    fsm_t        fsm_d;
    logic [7:0]  cnt_q;
    logic [1:0]  lvl_idx_q;
    logic [12:0] leaf_a_q;
    logic [12:0] leaf_b_q;
    logic [12:0] leaf_c_q;
    logic [12:0] leaf_d_q;
    logic [15:0] code_table_q;

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fsm_q <= S_IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // Next-state decode; abort overrides every transition
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            S_IDLE: if (start)                  fsm_d = S_REQ;
            S_REQ:  if (bus.lvl_valid)          fsm_d = S_RST;
            S_RST:  if (cnt_q == RST_LAST)      fsm_d = S_RUN;
            S_RUN:  if (cnt_q == RUN_LAST)      fsm_d = S_CAP;
            S_CAP:  fsm_d = (lvl_idx_q == LVL_LAST) ? S_DONE : S_REQ;
            S_DONE: fsm_d = S_IDLE;
            default: fsm_d = S_IDLE;
        endcase
        if (abort) begin
            fsm_d = S_IDLE;
        end
    end

    // Moore output decode from the registered state
    always_comb begin
        bus.lvl_req  = (fsm_q == S_REQ);
        bus.bld_nRST = !((fsm_q == S_IDLE) || (fsm_q == S_RST));
        busy         = (fsm_q != S_IDLE);
        lvl_done     = (fsm_q == S_CAP);
        done         = (fsm_q == S_DONE);
    end

    // Counter restarts on every state change and runs only inside the timed RST/RUN windows
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_q <= 8'd0;
        end else if ((fsm_q == S_RST || fsm_q == S_RUN) && fsm_d == fsm_q) begin
            cnt_q <= cnt_q + 8'd1;
        end else begin
            cnt_q <= 8'd0;
        end
    end

    // Level index, leaf latches and captured table; all frozen by abort
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            lvl_idx_q    <= 2'd0;
            leaf_a_q     <= 13'd0;
            leaf_b_q     <= 13'd0;
            leaf_c_q     <= 13'd0;
            leaf_d_q     <= 13'd0;
            code_table_q <= 16'd0;
        end else if (!abort) begin
            if (fsm_q == S_IDLE && start) begin
                lvl_idx_q <= 2'd0;
            end
            if (fsm_q == S_REQ && bus.lvl_valid) begin
                leaf_a_q <= bus.leaf_in_A;
                leaf_b_q <= bus.leaf_in_B;
                leaf_c_q <= bus.leaf_in_C;
                leaf_d_q <= bus.leaf_in_D;
            end
            if (fsm_q == S_CAP) begin
                code_table_q <= bus.code_in;
                if (lvl_idx_q != LVL_LAST) begin
                    lvl_idx_q <= lvl_idx_q + 2'd1;
                end
            end
        end
    end

    assign bus.lvl_idx = lvl_idx_q;
    assign bus.state   = lvl_idx_q;
    assign bus.leaf_A  = leaf_a_q;
    assign bus.leaf_B  = leaf_b_q;
    assign bus.leaf_C  = leaf_c_q;
    assign bus.leaf_D  = leaf_d_q;
    assign CODE_TABLE  = code_table_q;

endmodule
